// File: rtl/div_subshift_radix.sv
// Iterative restoring sub-and-shift divider resolving STEPS quotient bits per clock.
// Signed/unsigned operands, start/busy/done handshake, divide-by-zero and MIN/-1 overflow flags.
module div_subshift_radix #(
  parameter int DATA_W = 32,
  parameter int STEPS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam int N     = DATA_W / STEPS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(N - 1);
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  dvs_mag;   // divisor magnitude
  logic [DATA_W-1:0]  rem_r;     // partial remainder
  logic [DATA_W-1:0]  quo_r;     // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]  dvd_raw;
  logic               neg_q, neg_r, dz_r, ov_r;
  logic [DATA_W-1:0]  rem_nxt, quo_nxt;

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults first so no path through the block leaves a signal unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (cnt == LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // STEPS restoring steps chained combinationally; a clear borrow bit means the subtract fits.
  always_comb begin
    logic [DATA_W:0] trial;
    rem_nxt = rem_r;
    quo_nxt = quo_r;
    trial   = '0;
    for (int i = 0; i < STEPS; i++) begin
      trial = {rem_nxt, quo_nxt[DATA_W-1]} - {1'b0, dvs_mag};
      if (!trial[DATA_W]) rem_nxt = trial[DATA_W-1:0];
      else                rem_nxt = {rem_nxt[DATA_W-2:0], quo_nxt[DATA_W-1]};
      quo_nxt = {quo_nxt[DATA_W-2:0], ~trial[DATA_W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      dvs_mag     <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvd_raw     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_r        <= 1'b0;
      ov_r        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          dvd_raw <= dividend;
          quo_r   <= (sign && dividend[DATA_W-1]) ? neg(dividend) : dividend;
          dvs_mag <= (sign && divisor[DATA_W-1])  ? neg(divisor)  : divisor;
          rem_r   <= '0;
          cnt     <= '0;
          neg_q   <= sign && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
          neg_r   <= sign && dividend[DATA_W-1];
          dz_r    <= (divisor == '0);
          ov_r    <= sign && (dividend == MIN_VAL) && (divisor == '1);
        end
        S_CALC: begin
          rem_r <= rem_nxt;
          quo_r <= quo_nxt;
          cnt   <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz_r;
          overflow    <= ov_r;
          if (dz_r) begin
            quotient  <= '1;
            remainder <= dvd_raw;
          end else if (ov_r) begin
            quotient  <= MIN_VAL;
            remainder <= '0;
          end else begin
            quotient  <= neg_q ? neg(quo_r) : quo_r;
            remainder <= neg_r ? neg(rem_r) : rem_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_subshift_radix.sv
// Directed and random checks of div_subshift_radix, DATA_W=16, with STEPS=1 (unit 0) and STEPS=4 (unit 1).
module tb_div_subshift_radix;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start_v;
  logic        sign_i;
  logic [15:0] dvd, dvs;
  logic [1:0]  busy_v, done_v, dz_v, ov_v;
  logic [15:0] q_v [2];
  logic [15:0] r_v [2];

  int errors = 0;
  int checks = 0;

  logic [15:0] res_q [2];
  logic [15:0] res_r [2];
  logic [15:0] res_hold_q [2];
  logic        res_dz [2];
  logic        res_ov [2];
  int          res_lat [2];
  bit          res_busy_ok [2];

  always #5 clk = ~clk;

  div_subshift_radix #(.DATA_W(16), .STEPS(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sign(sign_i), .dividend(dvd), .divisor(dvs),
    .busy(busy_v[0]), .done(done_v[0]), .quotient(q_v[0]), .remainder(r_v[0]),
    .div_by_zero(dz_v[0]), .overflow(ov_v[0]));

  div_subshift_radix #(.DATA_W(16), .STEPS(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sign(sign_i), .dividend(dvd), .divisor(dvs),
    .busy(busy_v[1]), .done(done_v[1]), .quotient(q_v[1]), .remainder(r_v[1]),
    .div_by_zero(dz_v[1]), .overflow(ov_v[1]));

  function automatic int n_of(input int u);
    return (u == 0) ? 16 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic s, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov);
    dz = (b == 16'h0);
    ov = s && (a == 16'h8000) && (b == 16'hFFFF);
    if (dz)      begin q = 16'hFFFF; r = a; end
    else if (ov) begin q = 16'h8000; r = 16'h0; end
    else if (s)  begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else         begin q = a / b; r = a % b; end
  endtask

  // Called at a negedge; returns at the negedge of the last done among the masked units.
  task automatic do_div(input logic [1:0] mask, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input bit hold,
                        input logic [15:0] a2, input logic [15:0] b2);
    bit seen [2];
    sign_i = s;
    dvd    = a;
    dvs    = b;
    for (int u = 0; u < 2; u++) begin
      seen[u]        = !mask[u];
      res_lat[u]     = -1;
      res_busy_ok[u] = 1'b1;
      if (mask[u]) start_v[u] = 1'b1;
    end
    @(negedge clk);
    if (!hold) start_v = 2'b00;
    for (int j = 0; j <= 40; j++) begin
      for (int u = 0; u < 2; u++) begin
        if (!seen[u]) begin
          if (j == 0) res_hold_q[u] = q_v[u];
          if (done_v[u]) begin
            seen[u]    = 1'b1;
            res_lat[u] = j;
            res_q[u]   = q_v[u];
            res_r[u]   = r_v[u];
            res_dz[u]  = dz_v[u];
            res_ov[u]  = ov_v[u];
            if (busy_v[u]) res_busy_ok[u] = 1'b0;
            start_v[u] = 1'b0;
          end else if (!busy_v[u]) begin
            res_busy_ok[u] = 1'b0;
          end
        end
      end
      if (seen[0] && seen[1]) break;
      if (hold && j == 2) begin
        dvd = a2;
        dvs = b2;
      end
      @(negedge clk);
    end
    start_v = 2'b00;
  endtask

  task automatic check_res(input int u, input string tag, input logic [15:0] eq,
                           input logic [15:0] er, input logic edz, input logic eov);
    string t;
    t = $sformatf("%s/u%0d", tag, u);
    check({t, ".q"},    32'(res_q[u]),  32'(eq));
    check({t, ".r"},    32'(res_r[u]),  32'(er));
    check({t, ".dz"},   32'(res_dz[u]), 32'(edz));
    check({t, ".ov"},   32'(res_ov[u]), 32'(eov));
    check({t, ".lat"},  32'(res_lat[u]), 32'(n_of(u) + 1));
    check({t, ".busy"}, 32'(res_busy_ok[u]), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s/u%0d.busy", tag, u), 32'(busy_v[u]), 32'd0);
      check($sformatf("%s/u%0d.done", tag, u), 32'(done_v[u]), 32'd0);
      check($sformatf("%s/u%0d.q", tag, u),    32'(q_v[u]),    32'd0);
      check($sformatf("%s/u%0d.r", tag, u),    32'(r_v[u]),    32'd0);
      check($sformatf("%s/u%0d.dz", tag, u),   32'(dz_v[u]),   32'd0);
      check($sformatf("%s/u%0d.ov", tag, u),   32'(ov_v[u]),   32'd0);
    end
  endtask

  typedef struct {
    logic        s;
    logic [15:0] a, b, q, r;
    logic        dz, ov;
  } vec_t;

  vec_t dir_vecs [] = '{
    '{1'b0, 16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b0},
    '{1'b0, 16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0, 1'b0},
    '{1'b1, 16'hFFF9,  16'h0002,  16'hFFFD,  16'hFFFF,  1'b0, 1'b0},
    '{1'b1, 16'h0007,  16'hFFFE,  16'hFFFD,  16'h0001,  1'b0, 1'b0},
    '{1'b1, 16'hFFF9,  16'hFFFE,  16'h0003,  16'hFFFF,  1'b0, 1'b0},
    '{1'b0, 16'hFFF9,  16'h0002,  16'h7FFC,  16'h0001,  1'b0, 1'b0},
    '{1'b0, 16'h0007,  16'hFFFE,  16'h0000,  16'h0007,  1'b0, 1'b0},
    '{1'b0, 16'hFFF9,  16'hFFFE,  16'h0000,  16'hFFF9,  1'b0, 1'b0},
    '{1'b0, 16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1'b1, 1'b0},
    '{1'b1, 16'hFFFB,  16'h0000,  16'hFFFF,  16'hFFFB,  1'b1, 1'b0},
    '{1'b1, 16'h8000,  16'hFFFF,  16'h8000,  16'h0000,  1'b0, 1'b1},
    '{1'b0, 16'h8000,  16'hFFFF,  16'h0000,  16'h8000,  1'b0, 1'b0},
    '{1'b1, 16'h8000,  16'h0001,  16'h8000,  16'h0000,  1'b0, 1'b0},
    '{1'b0, 16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b0}
  };

  initial begin
    logic [15:0] a, b, eq, er;
    logic        edz, eov;
    int          dones;

    rst     = 1'b1;
    start_v = 2'b00;
    sign_i  = 1'b0;
    dvd     = '0;
    dvs     = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (dir_vecs[i]) begin
      do_div(2'b11, dir_vecs[i].s, dir_vecs[i].a, dir_vecs[i].b, 1'b0, 16'h0, 16'h0);
      for (int u = 0; u < 2; u++)
        check_res(u, $sformatf("dir%0d", i), dir_vecs[i].q, dir_vecs[i].r,
                  dir_vecs[i].dz, dir_vecs[i].ov);
      @(negedge clk);
    end

    // start held high with operands changed mid-CALC: first result must stand, no re-accept
    do_div(2'b11, 1'b0, 16'd200, 16'd9, 1'b1, 16'h1111, 16'h0001);
    for (int u = 0; u < 2; u++) check_res(u, "hold", 16'd22, 16'd2, 1'b0, 1'b0);
    @(negedge clk);
    for (int u = 0; u < 2; u++) check($sformatf("hold/u%0d.idle", u), 32'(busy_v[u]), 32'd0);

    // start in the done cycle is accepted; previous result held until the new FIX edge
    for (int u = 0; u < 2; u++) begin
      do_div((u == 0) ? 2'b01 : 2'b10, 1'b0, 16'd50, 16'd6, 1'b0, 16'h0, 16'h0);
      check_res(u, "chainA", 16'd8, 16'd2, 1'b0, 1'b0);
      do_div((u == 0) ? 2'b01 : 2'b10, 1'b1, 16'hFFCE, 16'd6, 1'b0, 16'h0, 16'h0);
      check_res(u, "chainB", 16'hFFF8, 16'hFFFE, 1'b0, 1'b0);
      check($sformatf("chainB/u%0d.held", u), 32'(res_hold_q[u]), 32'd8);
      check($sformatf("chainB/u%0d.space", u), 32'(res_lat[u] + 1), 32'(n_of(u) + 2));
      @(negedge clk);
    end

    // reset mid-CALC aborts without a done pulse
    for (int u = 0; u < 2; u++) begin
      sign_i = 1'b0;
      dvd = 16'd1000;
      dvs = 16'd3;
      start_v[u] = 1'b1;
      @(negedge clk);
      start_v = 2'b00;
      repeat ((u == 0) ? 5 : 2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero($sformatf("midrst%0d", u));
      dones = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (25) begin
        @(negedge clk);
        if (done_v[u]) dones++;
      end
      check($sformatf("midrst/u%0d.nodone", u), 32'(dones), 32'd0);
      do_div((u == 0) ? 2'b01 : 2'b10, 1'b0, 16'd9, 16'd3, 1'b0, 16'h0, 16'h0);
      check_res(u, "post_rst", 16'd3, 16'd0, 1'b0, 1'b0);
      @(negedge clk);
    end

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1000; i++) begin
        a = 16'($urandom);
        if ($urandom_range(0, 1) == 1) b = 16'($urandom_range(1, 255));
        else                           b = 16'($urandom);
        if (b == 16'h0) b = 16'h1;
        model(s[0], a, b, eq, er, edz, eov);
        do_div(2'b11, s[0], a, b, 1'b0, 16'h0, 16'h0);
        for (int u = 0; u < 2; u++) check_res(u, $sformatf("rnd_s%0d_%0d", s, i), eq, er, edz, eov);
      end
      for (int i = 0; i < 20; i++) begin
        a = 16'($urandom);
        model(s[0], a, 16'h0, eq, er, edz, eov);
        do_div(2'b11, s[0], a, 16'h0, 1'b0, 16'h0, 16'h0);
        for (int u = 0; u < 2; u++) check_res(u, $sformatf("dz_s%0d_%0d", s, i), eq, er, edz, eov);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
